// File: rtl/frac_pix_if.sv
// Pixel byte stream in, packed filter/reference rows out, for frac_pix_streamer.
// The master side drives the bytes; the slave side presents the packed rows.
interface frac_pix_if #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int ROW_W   = 3
);
    logic [PIX_W-1:0]         pix_in;
    logic                     pix_valid;
    logic                     pix_ready;
    logic                     flush;
    logic [ROW_PIX*PIX_W-1:0] filter_pix;
    logic [ROW_PIX*PIX_W-1:0] ref_pix;
    logic                     input_ready;
    logic [ROW_W-1:0]         row_idx;
    logic                     block_last;

    modport master (
        output pix_in, pix_valid, flush,
        input  pix_ready, filter_pix, ref_pix, input_ready, row_idx, block_last
    );

    modport slave (
        input  pix_in, pix_valid, flush,
        output pix_ready, filter_pix, ref_pix, input_ready, row_idx, block_last
    );
endinterface

// File: rtl/frac_pix_streamer.sv
// Byte-serial to row-parallel packer: ROW_PIX filter bytes then ROW_PIX reference bytes per row.
// Define FRAC_STREAM_PIPE_EN to drop the one-cycle EMIT bubble between rows.
module frac_pix_streamer #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int ROWS    = 8,
    parameter int ROW_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    frac_pix_if.slave  bus
);
    localparam int CNT_W = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam int ROW_BITS = ROW_PIX * PIX_W;

    typedef enum logic [1:0] {
        LOAD_FILT = 2'd0,
        LOAD_REF  = 2'd1,
        EMIT      = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [ROW_W-1:0]    row_cnt_reg, row_cnt_next;
    logic [ROW_BITS-1:0] filt_out_reg, filt_out_next;
    logic [ROW_BITS-1:0] ref_out_reg, ref_out_next;
    logic [ROW_W-1:0]    row_idx_reg, row_idx_next;
    logic                input_ready_reg, input_ready_next;
    logic                block_last_reg, block_last_next;

    logic [PIX_W-1:0]    filt_sh_reg [ROW_PIX];
    logic [PIX_W-1:0]    ref_sh_reg  [ROW_PIX];
    logic [ROW_BITS-1:0] filt_flat;
    logic [ROW_BITS-1:0] ref_flat;

    logic pix_ready;
    logic accept;
    logic count_last;
    logic filt_we;
    logic ref_we;

`ifdef FRAC_STREAM_PIPE_EN
    assign pix_ready = ~reset;
`else
    assign pix_ready = ~reset & (state_reg != EMIT);
`endif
    // flush drops any byte offered in the same cycle
    assign accept     = bus.pix_valid & pix_ready & ~bus.flush;
    assign count_last = (count_reg == CNT_W'(ROW_PIX - 1));

    genvar gi;
    generate
        for (gi = 0; gi < ROW_PIX; gi++) begin : g_pack
            assign filt_flat[gi*PIX_W +: PIX_W] = filt_sh_reg[gi];
`ifdef FRAC_STREAM_PIPE_EN
            // the final reference byte bypasses its shadow slot so the row loads on its accept
            if (gi == ROW_PIX - 1) begin : g_bypass
                assign ref_flat[gi*PIX_W +: PIX_W] = bus.pix_in;
            end else begin : g_shadow
                assign ref_flat[gi*PIX_W +: PIX_W] = ref_sh_reg[gi];
            end
`else
            assign ref_flat[gi*PIX_W +: PIX_W] = ref_sh_reg[gi];
`endif
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        row_cnt_next     = row_cnt_reg;
        filt_out_next    = filt_out_reg;
        ref_out_next     = ref_out_reg;
        row_idx_next     = row_idx_reg;
        input_ready_next = 1'b0;
        block_last_next  = 1'b0;
        filt_we          = 1'b0;
        ref_we           = 1'b0;

        if (bus.flush) begin
            state_next   = LOAD_FILT;
            count_next   = '0;
            row_cnt_next = '0;
        end else begin
            case (state_reg)
                LOAD_FILT: begin
                    if (accept) begin
                        filt_we = 1'b1;
                        if (count_last) begin
                            count_next = '0;
                            state_next = LOAD_REF;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
                LOAD_REF: begin
                    if (accept) begin
                        ref_we = 1'b1;
                        if (count_last) begin
                            count_next = '0;
`ifdef FRAC_STREAM_PIPE_EN
                            state_next       = LOAD_FILT;
                            filt_out_next    = filt_flat;
                            ref_out_next     = ref_flat;
                            input_ready_next = 1'b1;
                            row_idx_next     = row_cnt_reg;
                            block_last_next  = (row_cnt_reg == ROW_W'(ROWS - 1));
                            row_cnt_next     = (row_cnt_reg == ROW_W'(ROWS - 1)) ? '0 : row_cnt_reg + 1'b1;
`else
                            state_next = EMIT;
`endif
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    state_next       = LOAD_FILT;
                    filt_out_next    = filt_flat;
                    ref_out_next     = ref_flat;
                    input_ready_next = 1'b1;
                    row_idx_next     = row_cnt_reg;
                    block_last_next  = (row_cnt_reg == ROW_W'(ROWS - 1));
                    row_cnt_next     = (row_cnt_reg == ROW_W'(ROWS - 1)) ? '0 : row_cnt_reg + 1'b1;
                end
                default: begin
                    state_next = LOAD_FILT;
                    count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= LOAD_FILT;
            count_reg       <= '0;
            row_cnt_reg     <= '0;
            filt_out_reg    <= '0;
            ref_out_reg     <= '0;
            row_idx_reg     <= '0;
            input_ready_reg <= 1'b0;
            block_last_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            row_cnt_reg     <= row_cnt_next;
            filt_out_reg    <= filt_out_next;
            ref_out_reg     <= ref_out_next;
            row_idx_reg     <= row_idx_next;
            input_ready_reg <= input_ready_next;
            block_last_reg  <= block_last_next;
        end
    end

    // shadows need no reset: every slot is rewritten before a row is presented
    always_ff @(posedge clk) begin
        if (filt_we) begin
            filt_sh_reg[count_reg] <= bus.pix_in;
        end
        if (ref_we) begin
            ref_sh_reg[count_reg] <= bus.pix_in;
        end
    end

    assign bus.pix_ready   = pix_ready;
    assign bus.filter_pix  = filt_out_reg;
    assign bus.ref_pix     = ref_out_reg;
    assign bus.input_ready = input_ready_reg;
    assign bus.row_idx     = row_idx_reg;
    assign bus.block_last  = block_last_reg;
endmodule
